// File: rtl/seq_alu_pkg.sv
// Shared types and opcode helpers for the sequential ALU.
package seq_alu_pkg;

    typedef enum logic [3:0] {
        OP_AND = 4'b0000,
        OP_ADD = 4'b0001,
        OP_SUB = 4'b0010,
        OP_OR  = 4'b0011,
        OP_XOR = 4'b0100,
        OP_SHL = 4'b0101,
        OP_SHR = 4'b0110,
        OP_SRA = 4'b0111,
        OP_MUL = 4'b1000,
        OP_CMP = 4'b1001
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } flags_t;

    localparam flags_t FLAGS_CLEAR = flags_t'(4'b0000);

    // Opcodes 1010..1111 are undefined.
    function automatic logic op_is_legal(input logic [3:0] op);
        return (op <= 4'b1001);
    endfunction

    function automatic logic op_is_shift(input logic [3:0] op);
        return (op == OP_SHL) || (op == OP_SHR) || (op == OP_SRA);
    endfunction

    function automatic logic op_is_mul(input logic [3:0] op);
        return (op == OP_MUL);
    endfunction

endpackage

// File: rtl/seq_alu_if.sv
// Request/response bundle between the decode stage and the ALU.
interface seq_alu_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       op;
    logic             ci;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             flag_n;
    logic             flag_z;
    logic             flag_c;
    logic             flag_v;
    logic             illegal;

    modport master (
        output in_valid, a, b, op, ci, out_ready,
        input  in_ready, out_valid, result, flag_n, flag_z, flag_c, flag_v, illegal
    );

    modport slave (
        input  in_valid, a, b, op, ci, out_ready,
        output in_ready, out_valid, result, flag_n, flag_z, flag_c, flag_v, illegal
    );
endinterface

// File: rtl/seq_alu_comb.sv
// Single-cycle logic/arithmetic unit with N/Z/C/V generation.
// Also used with op=OR and b=0 as a pass-through to derive N/Z of a value.
module seq_alu_comb
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  op_t              op,
    input  logic             ci,
    output logic [WIDTH-1:0] res,
    output flags_t           flags
);

    logic [WIDTH:0]   sum_s;
    logic [WIDTH:0]   diff_s;
    logic [WIDTH-1:0] res_s;
    logic             c_s;
    logic             v_s;

    // Carry out of the top bit is the extra MSB; for subtraction it is "no borrow".
    assign sum_s  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, ci};
    assign diff_s = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};

    // Select the operation result and its carry/overflow.
    always_comb begin
        res_s = {WIDTH{1'b0}};
        c_s   = 1'b0;
        v_s   = 1'b0;
        case (op)
            OP_AND: res_s = a & b;
            OP_OR:  res_s = a | b;
            OP_XOR: res_s = a ^ b;
            OP_ADD: begin
                res_s = sum_s[WIDTH-1:0];
                c_s   = sum_s[WIDTH];
                v_s   = (a[WIDTH-1] == b[WIDTH-1]) && (sum_s[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB, OP_CMP: begin
                // CMP keeps the subtraction's C/V but passes a through as the result.
                if (op == OP_CMP) begin
                    res_s = a;
                end else begin
                    res_s = diff_s[WIDTH-1:0];
                end
                c_s = diff_s[WIDTH];
                v_s = (a[WIDTH-1] != b[WIDTH-1]) && (diff_s[WIDTH-1] != a[WIDTH-1]);
            end
            default: begin
                res_s = {WIDTH{1'b0}};
                c_s   = 1'b0;
                v_s   = 1'b0;
            end
        endcase
    end

    assign res   = res_s;
    assign flags = '{n: res_s[WIDTH-1], z: (res_s == {WIDTH{1'b0}}), c: c_s, v: v_s};

endmodule

// File: rtl/seq_alu.sv
// Handshaked multi-cycle ALU: single-cycle ops via seq_alu_comb, bit-serial
// shifts and a bit-serial unsigned shift-add multiplier.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic     clk,
    input  logic     rst,
    seq_alu_if.slave bus
);

    localparam int SW = $clog2(WIDTH);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] MUL_STEPS = CW'(WIDTH);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   result_q, result_d;
    flags_t             flags_q, flags_d;
    logic               illegal_q, illegal_d;
    op_t                op_q, op_d;
    logic [WIDTH-1:0]   sh_q, sh_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;

    logic               in_ready_s;
    logic               out_valid_s;
    logic               accept_s;
    logic               last_step_s;
    logic [SW-1:0]      shamt_s;
    logic [WIDTH-1:0]   sh_step_s;
    logic               sh_out_s;
    logic [2*WIDTH-1:0] acc_step_s;
    logic [WIDTH-1:0]   final_s;
    logic               mul_hi_nz_s;

    logic [WIDTH-1:0]   comb_a_s;
    logic [WIDTH-1:0]   comb_b_s;
    op_t                comb_op_s;
    logic               comb_ci_s;
    logic [WIDTH-1:0]   comb_res_s;
    flags_t             comb_flags_s;

    assign shamt_s     = bus.b[SW-1:0];
    assign accept_s    = bus.in_valid && in_ready_s;
    assign last_step_s = (state_q == ST_BUSY) && (cnt_q == CNT_ONE);

    // One serial step of the shifter and the multiplier.
    always_comb begin
        sh_step_s = sh_q;
        sh_out_s  = 1'b0;
        case (op_q)
            OP_SHL: begin
                sh_step_s = {sh_q[WIDTH-2:0], 1'b0};
                sh_out_s  = sh_q[WIDTH-1];
            end
            OP_SHR: begin
                sh_step_s = {1'b0, sh_q[WIDTH-1:1]};
                sh_out_s  = sh_q[0];
            end
            OP_SRA: begin
                sh_step_s = {sh_q[WIDTH-1], sh_q[WIDTH-1:1]};
                sh_out_s  = sh_q[0];
            end
            default: begin
                sh_step_s = sh_q;
                sh_out_s  = 1'b0;
            end
        endcase
        if (mplier_q[0]) begin
            acc_step_s = acc_q + mcand_q;
        end else begin
            acc_step_s = acc_q;
        end
    end

    assign final_s     = (op_q == OP_MUL) ? acc_step_s[WIDTH-1:0] : sh_step_s;
    assign mul_hi_nz_s = (acc_step_s[2*WIDTH-1:WIDTH] != {WIDTH{1'b0}});

    // Feed the combinational unit: live operands at acceptance, or the
    // serial result (passed through OR with zero) to derive its N/Z.
    always_comb begin
        comb_a_s  = bus.a;
        comb_b_s  = bus.b;
        comb_op_s = op_t'(bus.op);
        comb_ci_s = bus.ci;
        if (state_q == ST_BUSY) begin
            comb_a_s  = final_s;
            comb_b_s  = {WIDTH{1'b0}};
            comb_op_s = OP_OR;
            comb_ci_s = 1'b0;
        end else if (op_is_shift(bus.op) || op_is_mul(bus.op)) begin
            comb_a_s  = bus.a;
            comb_b_s  = {WIDTH{1'b0}};
            comb_op_s = OP_OR;
            comb_ci_s = 1'b0;
        end else begin
            comb_a_s  = bus.a;
            comb_b_s  = bus.b;
        end
    end

    seq_alu_comb #(.WIDTH(WIDTH)) u_comb (
        .a     (comb_a_s),
        .b     (comb_b_s),
        .op    (comb_op_s),
        .ci    (comb_ci_s),
        .res   (comb_res_s),
        .flags (comb_flags_s)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    if (!op_is_legal(bus.op)) begin
                        state_d = ST_DONE;
                    end else if (op_is_mul(bus.op)) begin
                        state_d = ST_BUSY;
                    end else if (op_is_shift(bus.op) && (shamt_s != {SW{1'b0}})) begin
                        state_d = ST_BUSY;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (last_step_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_BUSY;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM output decode.
    always_comb begin
        in_ready_s  = 1'b0;
        out_valid_s = 1'b0;
        case (state_q)
            ST_IDLE: in_ready_s  = 1'b1;
            ST_DONE: out_valid_s = 1'b1;
            default: begin
                in_ready_s  = 1'b0;
                out_valid_s = 1'b0;
            end
        endcase
    end

    // Datapath: capture at acceptance, serial steps in BUSY, result on DONE entry.
    always_comb begin
        result_d  = result_q;
        flags_d   = flags_q;
        illegal_d = illegal_q;
        op_d      = op_q;
        sh_d      = sh_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    op_d = op_t'(bus.op);
                    if (!op_is_legal(bus.op)) begin
                        result_d  = {WIDTH{1'b0}};
                        flags_d   = FLAGS_CLEAR;
                        illegal_d = 1'b1;
                    end else if (op_is_shift(bus.op)) begin
                        sh_d  = bus.a;
                        cnt_d = CW'(shamt_s);
                        if (shamt_s == {SW{1'b0}}) begin
                            result_d  = bus.a;
                            flags_d   = '{n: comb_flags_s.n, z: comb_flags_s.z, c: 1'b0, v: 1'b0};
                            illegal_d = 1'b0;
                        end else begin
                            result_d = result_q;
                        end
                    end else if (op_is_mul(bus.op)) begin
                        acc_d    = {(2*WIDTH){1'b0}};
                        mcand_d  = {{WIDTH{1'b0}}, bus.a};
                        mplier_d = bus.b;
                        cnt_d    = MUL_STEPS;
                    end else begin
                        result_d  = comb_res_s;
                        flags_d   = comb_flags_s;
                        illegal_d = 1'b0;
                    end
                end else begin
                    op_d = op_q;
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q - CNT_ONE;
                if (op_q == OP_MUL) begin
                    acc_d    = acc_step_s;
                    mcand_d  = {mcand_q[2*WIDTH-2:0], 1'b0};
                    mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
                end else begin
                    sh_d = sh_step_s;
                end
                if (last_step_s) begin
                    result_d  = final_s;
                    illegal_d = 1'b0;
                    if (op_q == OP_MUL) begin
                        flags_d = '{n: comb_flags_s.n, z: comb_flags_s.z, c: mul_hi_nz_s, v: mul_hi_nz_s};
                    end else begin
                        flags_d = '{n: comb_flags_s.n, z: comb_flags_s.z, c: sh_out_s, v: 1'b0};
                    end
                end else begin
                    result_d = result_q;
                end
            end
            default: begin
                result_d = result_q;
            end
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q  <= {WIDTH{1'b0}};
            flags_q   <= FLAGS_CLEAR;
            illegal_q <= 1'b0;
            op_q      <= OP_AND;
            sh_q      <= {WIDTH{1'b0}};
            cnt_q     <= {CW{1'b0}};
            acc_q     <= {(2*WIDTH){1'b0}};
            mcand_q   <= {(2*WIDTH){1'b0}};
            mplier_q  <= {WIDTH{1'b0}};
        end else begin
            result_q  <= result_d;
            flags_q   <= flags_d;
            illegal_q <= illegal_d;
            op_q      <= op_d;
            sh_q      <= sh_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_s;
    assign bus.result    = result_q;
    assign bus.flag_n    = flags_q.n;
    assign bus.flag_z    = flags_q.z;
    assign bus.flag_c    = flags_q.c;
    assign bus.flag_v    = flags_q.v;
    assign bus.illegal   = illegal_q;

endmodule

// File: tb/tb_seq_alu.sv
// Randomized scoreboard bench for seq_alu (WIDTH=8).
module tb_seq_alu;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] res;
        logic         n, z, c, v, ill;
        int           lat;
        time          acc_t;
    } exp_t;

    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    int   bp_mode = 0;   // 0 random out_ready, 1 hold low, 2 hold high
    exp_t sb_q[$];

    seq_alu_if #(.WIDTH(W)) bus ();

    seq_alu #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model from the opcode definitions.
    function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a,
                                   input logic [W-1:0] b, input logic ci);
        exp_t e;
        int s, sa, sb;
        logic [W:0] w9;
        logic [2*W-1:0] p;
        e.res = '0; e.c = 1'b0; e.v = 1'b0; e.ill = 1'b0; e.lat = 1; e.acc_t = 0;
        s  = int'(b) % W;
        sa = int'($signed(a));
        sb = int'($signed(b));
        case (op)
            4'd0: e.res = a & b;
            4'd1: begin
                w9 = {1'b0, a} + {1'b0, b} + {8'd0, ci};
                e.res = w9[W-1:0];
                e.c = w9[W];
                e.v = (sa + sb + int'(ci) > 127) || (sa + sb + int'(ci) < -128);
            end
            4'd2, 4'd9: begin
                e.res = (op == 4'd9) ? a : (a - b);
                e.c = (a >= b);
                e.v = (sa - sb > 127) || (sa - sb < -128);
            end
            4'd3: e.res = a | b;
            4'd4: e.res = a ^ b;
            4'd5: begin
                e.res = a << s;
                if (s > 0) e.c = a[W-s];
                e.lat = s + 1;
            end
            4'd6: begin
                e.res = a >> s;
                if (s > 0) e.c = a[s-1];
                e.lat = s + 1;
            end
            4'd7: begin
                e.res = $signed(a) >>> s;
                if (s > 0) e.c = a[s-1];
                e.lat = s + 1;
            end
            4'd8: begin
                p = (2*W)'(a) * (2*W)'(b);
                e.res = p[W-1:0];
                e.c = (p[2*W-1:W] != 0);
                e.v = e.c;
                e.lat = W + 1;
            end
            default: e.ill = 1'b1;
        endcase
        e.n = e.ill ? 1'b0 : e.res[W-1];
        e.z = e.ill ? 1'b0 : (e.res == 0);
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Issue one request, hold it until accepted, optionally push its expectation.
    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic ci, input bit expect_it);
        int waited = 0;
        exp_t e;
        @(negedge clk);
        bus.op = op; bus.a = a; bus.b = b; bus.ci = ci; bus.in_valid = 1'b1;
        while (!bus.in_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.in_ready) begin
            errors++; checks++;
            $display("FAIL accept_timeout: in_ready never rose for op %h", op);
            bus.in_valid = 1'b0;
        end else begin
            @(posedge clk);
            if (expect_it) begin
                e = model(op, a, b, ci);
                e.acc_t = $time;
                sb_q.push_back(e);
            end
            #1;
            bus.in_valid = 1'b0;
            bus.a = W'($urandom); bus.b = W'($urandom);
            bus.op = 4'($urandom); bus.ci = 1'($urandom);
        end
    endtask

    task automatic drain();
        int w = 0;
        while ((sb_q.size() != 0 || bus.out_valid) && w < 300) begin
            @(negedge clk);
            w++;
        end
        if (sb_q.size() != 0) begin
            errors++; checks++;
            $display("FAIL drain_timeout: %0d results outstanding", sb_q.size());
        end
    endtask

    // Consumer-side ready generation.
    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (bp_mode)
                0:       bus.out_ready = ($urandom_range(0, 3) != 0);
                1:       bus.out_ready = 1'b0;
                default: bus.out_ready = 1'b1;
            endcase
        end
    end

    // Monitor: latency, stability under backpressure, in_ready, scoreboard compare.
    initial begin
        bit seen = 1'b0;
        logic [W+4:0] held = '0;
        logic [W+4:0] now_v;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && bus.out_valid) begin
                now_v = {bus.result, bus.flag_n, bus.flag_z, bus.flag_c, bus.flag_v, bus.illegal};
                check("in_ready_low_in_done", 32'(bus.in_ready), 32'd0);
                if (sb_q.size() == 0) begin
                    errors++; checks++;
                    $display("FAIL unexpected_out_valid: result %h expected none", bus.result);
                end else begin
                    e = sb_q[0];
                    if (!seen) begin
                        seen = 1'b1;
                        held = now_v;
                        check("latency", 32'(int'(($time - 5 - e.acc_t) / 10) + 1), 32'(e.lat));
                    end else begin
                        check("stable_under_backpressure", 32'(now_v), 32'(held));
                    end
                    if (bus.out_ready) begin
                        void'(sb_q.pop_front());
                        seen = 1'b0;
                        check("result", 32'(bus.result), 32'(e.res));
                        check("flags_nzcv", {28'd0, bus.flag_n, bus.flag_z, bus.flag_c, bus.flag_v},
                              {28'd0, e.n, e.z, e.c, e.v});
                        check("illegal", 32'(bus.illegal), 32'(e.ill));
                    end
                end
            end
        end
    end

    initial begin
        bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.op = '0; bus.ci = 1'b0;
        rst = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("reset_in_ready", 32'(bus.in_ready), 32'd1);
        check("reset_out_valid", 32'(bus.out_valid), 32'd0);
        check("reset_outputs", {19'd0, bus.result, bus.flag_n, bus.flag_z, bus.flag_c, bus.flag_v, bus.illegal}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Directed cases.
        issue(4'b0001, 8'hFF, 8'h01, 1'b0, 1'b1);
        issue(4'b0010, 8'h03, 8'h05, 1'b0, 1'b1);
        issue(4'b0010, 8'h80, 8'h01, 1'b0, 1'b1);
        issue(4'b1001, 8'h05, 8'h05, 1'b0, 1'b1);
        issue(4'b0101, 8'h81, 8'h03, 1'b0, 1'b1);
        issue(4'b0110, 8'h03, 8'h01, 1'b0, 1'b1);
        issue(4'b0111, 8'h90, 8'h02, 1'b0, 1'b1);
        issue(4'b0101, 8'h81, 8'h0B, 1'b0, 1'b1);
        issue(4'b0110, 8'hA5, 8'h00, 1'b0, 1'b1);
        issue(4'b1000, 8'h10, 8'h10, 1'b0, 1'b1);
        issue(4'b1000, 8'h0C, 8'h0B, 1'b0, 1'b1);
        issue(4'b0001, 8'h7F, 8'h00, 1'b1, 1'b1);
        issue(4'b1100, 8'h12, 8'h34, 1'b1, 1'b1);
        drain();

        // Backpressure with a second request pending.
        bp_mode = 1;
        issue(4'b0100, 8'h5A, 8'h0F, 1'b0, 1'b1);
        fork
            issue(4'b0001, 8'h20, 8'h22, 1'b1, 1'b1);
            begin
                int w = 0;
                while (!bus.out_valid && w < 20) begin
                    @(negedge clk);
                    w++;
                end
                repeat (5) @(negedge clk);
                bp_mode = 2;
                @(posedge clk);
                #2;
                @(posedge clk);
                #2;
                check("idle_after_handshake", {30'd0, bus.in_ready, bus.out_valid}, 32'd2);
            end
        join
        drain();
        bp_mode = 0;

        // Reset during the third BUSY cycle of a multiply.
        issue(4'b1000, 8'hFF, 8'hFF, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_out_valid", 32'(bus.out_valid), 32'd0);
        check("abort_result", 32'(bus.result), 32'd0);
        check("abort_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        issue(4'b0001, 8'h02, 8'h03, 1'b0, 1'b1);
        drain();

        // Randomized traffic.
        for (int i = 0; i < 200; i++) begin
            issue(4'($urandom_range(0, 15)), W'($urandom), W'($urandom), 1'($urandom), 1'b1);
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
# seq_alu

Multi-cycle, handshaked ALU with registered result and N/Z/C/V flags, generalised to any operand width. It sits between the decode stage and the register-file writeback in the processor datapath. Single-cycle logic and add/sub ops complete in one cycle. Shifts run one bit per cycle, and an unsigned shift-add multiplier runs one bit per cycle. Results use plain two's complement; no sign-magnitude conversion is applied.

## Interface
- WIDTH, 8, operand/result width in bits (true width; MSB index is WIDTH-1); minimum 4.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept a request (high only in IDLE).
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B; for shifts, b[$clog2(WIDTH)-1:0] is the shift amount s.
- op  in  4  opcode (see Operation).
- ci  in  1  carry-in, used by ADD only.
- out_valid  out  1  result and flags valid.
- out_ready  in  1  consumer accepts result.
- result  out  WIDTH  registered result.
- flag_n, flag_z, flag_c, flag_v  out  1 each  registered negative/zero/carry/overflow flags.
- illegal  out  1  registered; high with out_valid when op was undefined.

## Operation
- Opcodes:
  - 0000 AND: a&b.
  - 0001 ADD: a+b+ci.
  - 0010 SUB: a+~b+1.
  - 0011 OR.
  - 0100 XOR.
  - 0101 SHL: logical left by s.
  - 0110 SHR: logical right by s.
  - 0111 SRA: arithmetic right by s.
  - 1000 MUL: low WIDTH bits of unsigned a*b.
  - 1001 CMP: SUB flags, result = a.
  - 1010–1111: illegal.
- FSM:
  - IDLE -> (in_valid && in_ready) -> single-cycle op, shift with s=0, or illegal: DONE; shift with s>0, or MUL: BUSY.
  - BUSY -> DONE after the last step.
  - DONE -> (out_valid && out_ready) -> IDLE.
- Operands, op and ci are captured at acceptance. Input changes during BUSY/DONE are ignored, and in_valid outside IDLE is ignored.
- Flags:
  - Z is result==0.
  - N is result[WIDTH-1].
  - ADD: C = carry out of bit WIDTH-1; V = signed overflow (operand signs equal, result sign differs).
  - SUB/CMP: C = no-borrow (1 when a >= b unsigned); V = signed overflow of a-b.
  - AND/OR/XOR: C=V=0.
  - Shifts: C = last bit shifted out (0 when s=0); V=0.
  - MUL: C=V=1 when the upper WIDTH bits of the 2·WIDTH product are nonzero, else 0.
  - Illegal op: result=0, all flags 0, illegal=1.
- Shift amount uses only the low $clog2(WIDTH) bits of b; the upper bits of b are ignored.
- result, flags and illegal hold their values from DONE until the next DONE entry. They are not cleared on return to IDLE.

## Timing
- Latency L is counted in cycles from the accepting edge to out_valid high:
  - single-cycle ops, shift with s=0, and illegal: L=1.
  - shift with s>0: L=s+1.
  - MUL: L=WIDTH+1.
- No back-to-back acceptance: in_ready=0 during BUSY and DONE. The next request can be accepted one cycle after the output handshake.
- Backpressure: while out_valid=1 and out_ready=0, result, flags and illegal are stable.
- The output handshake and a new in_valid in the same cycle do not cause acceptance. The new request is accepted in the following IDLE cycle if it is still asserted.
- Reset values, applied immediately on rst with no clock required:
  - state IDLE, so in_ready=1.
  - out_valid=0, result=0, all flags 0, illegal=0.
  - shift/multiply counters and accumulators cleared.
- rst asserted during BUSY or DONE aborts the operation and drops its result. No request is accepted while rst is high.

## Structure
- The shared package seq_alu_pkg holds:
  - the op_t enum (opcodes above).
  - the state_t enum (IDLE, BUSY, DONE).
  - the flags_t packed struct {n, z, c, v}.
- One sub-module, seq_alu_comb: a purely combinational single-cycle unit (AND/ADD/SUB/OR/XOR/CMP plus flag generation). It is used at acceptance and reused for final Z/N evaluation.
- The shift and multiply datapaths and the FSM live in seq_alu.

## Test plan
All scenarios use WIDTH=8.
- ADD a=8'hFF, b=8'h01, ci=0 -> result 8'h00; Z=1, C=1, V=0, N=0; out_valid at L=1.
- SUB 8'h03-8'h05 -> 8'hFB, N=1, C=0, V=0. SUB 8'h80-8'h01 -> 8'h7F, C=1, V=1. CMP 8'h05,8'h05 -> result 8'h05, Z=0, C=1.
- SHL a=8'h81, b=3 -> 8'h08, C=0, L=4. SHR a=8'h03, b=1 -> 8'h01, C=1, L=2. SRA a=8'h90, b=2 -> 8'hE4, N=1, L=3. SHL b=8'h0B -> effective s=3.
- MUL 8'h10*8'h10 -> 8'h00, Z=1, C=V=1, L=9. MUL 8'h0C*8'h0B -> 8'h84, N=1, C=V=0.
- Backpressure: hold out_ready=0 for 5 cycles with in_valid=1 -> result/flags unchanged and in_ready=0. Release -> IDLE next cycle, second op accepted, its result correct. op=4'b1100 -> result 0, illegal=1.
- Reset mid-MUL: assert rst in the 3rd BUSY cycle -> out_valid=0, result=0 and in_ready=1 before the next edge. After release, ADD 8'h02+8'h03 -> 8'h05 at L=1.
